placement_readback: RTL
=======================

Name: placement_readback

Overview:
- Reader side of the placement grid/position RAMs: after the placer finishes, scans every grid cell in row-major order.
- For each occupied cell it reads the node's pos_X/pos_Y entries, cross-checks them against the cell coordinates, and streams (x, y, node, mismatch) out on a valid/ready interface.
- Sits beside placement, sharing grid/pos RAMs through a mux owned by the top level. Used for result dumping and self-check.

Parameters:
- N, 8, grid side; grid has N*N cells, address = x*N+y.
- V, 11, number of nodes; valid node ids are 0..V-1.
- RD_LAT, 2, cycles from read strobe to usable dout, matching memoryRAM plus wait state.
- W, 32, data/address width, signed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a scan; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the scan completes
- reGrid  out  1  grid read strobe
- addrGrid  out  W  grid read address
- doutGrid  in  W  grid read data; -1 marks an empty cell
- rePX / rePY  out  1  position RAM read strobes, always asserted together
- addrPos  out  W  node address, shared by pos_X and pos_Y
- doutPX / doutPY  in  W  position read data
- out_valid  out  1  record valid
- out_ready  in  1  consumer accept
- out_x / out_y  out  W  cell coordinates of the record
- out_node  out  W  node id stored in the cell
- out_mismatch  out  1  pos RAM disagrees with the cell, or node id out of range
- occ_count  out  W  occupied cells found in the current/last scan
- err_count  out  W  records emitted with mismatch=1

Behaviour:
- Reset values: all outputs 0, state IDLE, x=y=0. Reset mid-scan aborts immediately; done is not pulsed.
- Read strobes are one-cycle pulses, default 0 every cycle.
- States:
  - IDLE: on start, clear occ_count and err_count, set x=y=0, go to G_RD.
  - G_RD: reGrid=1, addrGrid=x*N+y, go to G_WAIT.
  - G_WAIT: wait RD_LAT-1 cycles, latch doutGrid into node.
  - G_CHK:
    - node==-1: go to NEXT.
    - node<0 or node>=V: set mismatch=1, skip the pos reads, go to EMIT.
    - otherwise: go to P_RD.
  - P_RD: rePX=rePY=1, addrPos=node, go to P_WAIT.
  - P_WAIT: wait RD_LAT-1 cycles.
  - CMP: mismatch = (doutPX!=x) or (doutPY!=y), go to EMIT.
  - EMIT: out_valid=1 with out_x/out_y/out_node/out_mismatch held stable until out_valid&&out_ready. On the handshake cycle, occ_count+1 and err_count+mismatch, then go to NEXT. Outputs must not change while valid&&!ready.
  - NEXT:
    - y==N-1 and x==N-1: go to DONE.
    - y==N-1 otherwise: y=0, x+1.
    - else: y+1.
    - then go to G_RD.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- out_valid deasserts the cycle after the handshake. Back-to-back records are separated by at least one full read round.
- start coincident with the DONE cycle is ignored; start on the following IDLE cycle is accepted.
- Address arithmetic is W-bit unsigned; N*N must be < 2^(W-1).
- All comparisons are signed.
- Per-occupied-cell latency with out_ready tied high: 1 + RD_LAT + 1 + 1 + RD_LAT + 1 + 1 + 1 cycles. Empty cell: 1 + RD_LAT + 1 + 1.

Decomposition:
- Shared package placement_pkg holds:
  - state encoding constants (IDLE..DONE, distinct values);
  - EMPTY_CELL = -1;
  - the cell address function x*N+y, also used by placement.
- One sub-module is natural: rd_wait_ctr, a down-counter of RD_LAT-1 cycles with load/zero. It is shared by G_WAIT and P_WAIT.

Test Plan:
- Empty grid (all -1), N=8: start -> no out_valid ever; done exactly 1 + 64*(RD_LAT+3) cycles after start; occ_count=0.
- Node 3 at cell (2,5) with pos_X[3]=2, pos_Y[3]=5, rest empty -> one record x=2, y=5, node=3, mismatch=0; occ_count=1, err_count=0.
- Same setup but pos_Y[3]=4 -> record mismatch=1, err_count=1.
- Cell (0,0) holds 11 with V=11 -> mismatch=1, rePX never pulsed for that cell.
- Two nodes, out_ready held low for 10 cycles then high -> first record stable for all 10 cycles, exactly 2 handshakes, records in row-major order.
- Reset asserted mid-EMIT -> next cycle out_valid=0, busy=0, counts=0, no done. Start afterwards -> full scan repeats correctly. Start pulsed during busy -> no effect.

Source files
------------

// File: rtl/placement_pkg.sv
// placement_pkg: shared state encoding, empty-cell marker and cell addressing
package placement_pkg;
    localparam int W = 32;
    localparam logic signed [W-1:0] EMPTY_CELL = -1;
    typedef enum logic [3:0] {IDLE, G_RD, G_WAIT, G_CHK, P_RD, P_WAIT, CMP, EMIT, NEXT, DONE} state_t;
    function automatic logic [W-1:0] cell_addr(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] n);
        return x * n + y;
    endfunction
endpackage

// File: rtl/placement_readback_if.sv
// placement_readback_if: grid/pos RAM read ports plus the record stream
interface placement_readback_if import placement_pkg::*;;
    logic         reGrid;
    logic [W-1:0] addrGrid;
    logic [W-1:0] doutGrid;
    logic         rePX;
    logic         rePY;
    logic [W-1:0] addrPos;
    logic [W-1:0] doutPX;
    logic [W-1:0] doutPY;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic [W-1:0] out_node;
    logic         out_mismatch;
    modport master (output reGrid, addrGrid, rePX, rePY, addrPos, out_valid, out_x, out_y, out_node, out_mismatch,
                    input doutGrid, doutPX, doutPY, out_ready);
    modport slave (input reGrid, addrGrid, rePX, rePY, addrPos, out_valid, out_x, out_y, out_node, out_mismatch,
                   output doutGrid, doutPX, doutPY, out_ready);
endinterface

// File: rtl/rd_wait_ctr.sv
// rd_wait_ctr: RAM read wait counter, zero after LAT cycles of waiting following load
module rd_wait_ctr #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero
);
    localparam int CW = $clog2(LAT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign zero = cnt_q == '0;
    always_comb cnt_d = load ? CW'(LAT - 1) : (zero ? cnt_q : cnt_q - CW'(1));
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/placement_readback.sv
// placement_readback: row-major grid scan that cross-checks node positions and streams records
module placement_readback import placement_pkg::*; #(
    parameter int N = 8,
    parameter int V = 11,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         occ_count,
    output logic [W-1:0]         err_count,
    placement_readback_if.master bus
);
    state_t state_q, state_d;
    logic [W-1:0] x_q, x_d, y_q, y_d, occ_q, occ_d, err_q, err_d;
    logic signed [W-1:0] node_q, node_d;
    logic mm_q, mm_d, load, zero, last_col, last_cell;

    rd_wait_ctr #(.LAT(RD_LAT)) u_ctr (.clk(clk), .reset(reset), .load(load), .zero(zero));

    assign busy = state_q != IDLE && state_q != DONE;
    assign done = state_q == DONE;
    assign occ_count = occ_q;
    assign err_count = err_q;
    assign bus.reGrid = state_q == G_RD;
    assign bus.addrGrid = cell_addr(x_q, y_q, W'(N));
    assign bus.rePX = state_q == P_RD;
    assign bus.rePY = state_q == P_RD;
    assign bus.addrPos = node_q;
    assign bus.out_valid = state_q == EMIT;
    assign bus.out_x = x_q;
    assign bus.out_y = y_q;
    assign bus.out_node = node_q;
    assign bus.out_mismatch = mm_q;
    assign last_col = y_q == W'(N - 1);
    assign last_cell = last_col && x_q == W'(N - 1);

    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        node_d = node_q;
        mm_d = mm_q;
        occ_d = occ_q;
        err_d = err_q;
        load = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                occ_d = '0;
                err_d = '0;
                x_d = '0;
                y_d = '0;
                state_d = G_RD;
            end
            G_RD: begin
                load = 1'b1;
                state_d = G_WAIT;
            end
            G_WAIT: if (zero) begin
                node_d = bus.doutGrid;
                state_d = G_CHK;
            end
            G_CHK: begin
                mm_d = node_q != EMPTY_CELL && (node_q < 0 || node_q >= V);
                state_d = node_q == EMPTY_CELL ? NEXT : (mm_d ? EMIT : P_RD);
            end
            P_RD: begin
                load = 1'b1;
                state_d = P_WAIT;
            end
            P_WAIT: state_d = zero ? CMP : P_WAIT;
            CMP: begin
                mm_d = bus.doutPX != x_q || bus.doutPY != y_q;
                state_d = EMIT;
            end
            EMIT: if (bus.out_ready) begin
                occ_d = occ_q + W'(1);
                err_d = err_q + W'(mm_q);
                state_d = NEXT;
            end
            NEXT: begin
                mm_d = 1'b0;
                y_d = last_col ? '0 : y_q + W'(1);
                x_d = last_col && !last_cell ? x_q + W'(1) : x_q;
                state_d = last_cell ? DONE : G_RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            node_q <= '0;
            mm_q <= 1'b0;
            occ_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            node_q <= node_d;
            mm_q <= mm_d;
            occ_q <= occ_d;
            err_q <= err_d;
        end
    end
endmodule
